// File: rtl/clk_div_sched.sv
// Programmable clock divider: registered div_clk plus a one-cycle tick in the last cycle of each period.
// Latency: div_clk/busy rise the cycle after a start is accepted; divisor changes and stops land at the next period wrap.
// Backpressure: cfg_ready drops while a change/stop is pending and returns on the wrap that applies it.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_valid/cfg_ready configuration handshake (cfg_ready combinational from state)
//   cfg_run, cfg_div    1 = run with divisor cfg_div, 0 = stop at the next boundary
//   div_clk, tick       divided clock and end-of-period tick (both registered)
//   busy, cfg_err       divider active; one-cycle pulse for a rejected divisor (< 2)
//
// Build option: define CLK_DIV_AUTOSTART_EN to leave reset already running at DEFAULT_DIV.
module clk_div_sched #(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(500000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_run,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             div_clk,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

`ifdef CLK_DIV_AUTOSTART_EN
    localparam state_t RST_STATE = ST_RUN;
    localparam logic   RST_BOOT  = 1'b1;
`else
    localparam state_t RST_STATE = ST_STOP;
    localparam logic   RST_BOOT  = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] nxt_div_q, nxt_div_d;
    logic             nxt_run_q, nxt_run_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    // boot_q covers the first cycle after reset when starting automatically:
    // cnt is held at 0 for one edge so the first period is full length.
    logic             boot_q, boot_d;

    logic             xfer;
    logic             div_ok;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   hi_d;

    assign cfg_ready = (state_q != ST_PEND) && !boot_q;
    assign busy      = (state_q != ST_STOP) && !boot_q;
    assign div_clk   = div_clk_q;
    assign tick      = tick_q;
    assign cfg_err   = cfg_err_q;

    assign xfer    = cfg_valid && cfg_ready;
    assign div_ok  = cfg_div >= CNT_W'(2);
    assign wrap    = cnt_q == (div_q - CNT_W'(1));
    assign cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        nxt_div_d = nxt_div_q;
        nxt_run_d = nxt_run_q;
        cfg_err_d = 1'b0;
        boot_d    = 1'b0;
        div_clk_d = 1'b0;
        tick_d    = 1'b0;
        hi_d      = '0;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (xfer && cfg_run) begin
                    if (div_ok) begin
                        div_d   = cfg_div;
                        state_d = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = boot_q ? '0 : cnt_inc;
                if (xfer) begin
                    if (cfg_run && !div_ok) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        nxt_run_d = cfg_run;
                        nxt_div_d = cfg_div;
                        state_d   = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (nxt_run_q) begin
                        div_d   = nxt_div_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_STOP;
            end
        endcase

        // Outputs are registered from the next counter/divisor so they line up
        // with cnt_q in the same cycle. hi is computed one bit wider so that
        // div = 2^CNT_W-1 does not overflow.
        hi_d = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
        if (state_d != ST_STOP) begin
            div_clk_d = {1'b0, cnt_d} < hi_d;
            tick_d    = cnt_d == (div_d - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            div_q     <= DEFAULT_DIV;
            nxt_div_q <= DEFAULT_DIV;
            nxt_run_q <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            boot_q    <= RST_BOOT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            nxt_div_q <= nxt_div_d;
            nxt_run_q <= nxt_run_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
            boot_q    <= boot_d;
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched: scenario tasks driving a period-level reference model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: requests are held until the model-predicted cfg_ready accepts them.
module tb_clk_div_sched;

`ifdef CLK_DIV_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_run;
    logic [31:0] cfg_div;
    logic        div_clk;
    logic        tick;
    logic        busy;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_run   (cfg_run),
        .cfg_div   (cfg_div),
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the divider is described as a sequence of periods.
    // Each period has a length N and an absolute start cycle; the waveform
    // within it follows from the position (cyc - m_start).
    longint unsigned cyc = 0;
    longint unsigned m_n, m_start, m_pdiv;
    bit m_run, m_pend, m_prun, m_err, m_boot;
    bit last_xfer;

    function automatic logic [4:0] obs_vec();
        return {div_clk, tick, busy, cfg_ready, cfg_err};
    endfunction

    function automatic logic [4:0] exp_vec();
        longint unsigned pos;
        logic dclk, tk;
        pos  = cyc - m_start;
        dclk = m_run && (pos < (m_n + 1) / 2);
        tk   = m_run && (pos == m_n - 1);
        return {dclk, tk, m_run, !(m_pend || m_boot), m_err};
    endfunction

    function automatic void model_reset();
        m_run   = 1'b0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_boot  = AUTO;
        m_n     = 500000;
        m_start = cyc;
    endfunction

    task automatic step();
        bit xfer, crun, was_run;
        longint unsigned cdiv;
        xfer = cfg_valid && !m_pend && !m_boot;
        crun = cfg_run;
        cdiv = cfg_div;
        @(posedge clk);
        cyc++;
        was_run = m_run;
        m_err   = 1'b0;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_run   = 1'b1;
            m_start = cyc;
        end else if (m_run && cyc == m_start + m_n) begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_prun) begin
                    m_n     = m_pdiv;
                    m_start = cyc;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_start = cyc;
            end
        end
        if (xfer) begin
            if (crun && cdiv < 2) begin
                m_err = 1'b1;
            end else if (!was_run) begin
                if (crun) begin
                    m_run   = 1'b1;
                    m_n     = cdiv;
                    m_start = cyc;
                end
            end else begin
                m_pend = 1'b1;
                m_prun = crun;
                m_pdiv = cdiv;
            end
        end
        last_xfer = xfer;
        #1;
    endtask

    task automatic apply_reset();
        cfg_valid = 1'b0;
        cfg_run   = 1'b0;
        cfg_div   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one request that is accepted on the next edge (caller ensures ready).
    task automatic request(input bit run, input logic [31:0] div);
        cfg_valid = 1'b1;
        cfg_run   = run;
        cfg_div   = div;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_run   = 1'b0;
        cfg_div   = '0;
        #12;
        n_cmp++;
        if (obs_vec() !== {1'b0, 1'b0, 1'b0, !AUTO, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs_vec(), {1'b0, 1'b0, 1'b0, !AUTO, 1'b0});
        end
        apply_reset();
        repeat (4) begin
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_start(input logic [31:0] n);
        logic [7:0] dpat, tpat;
        apply_reset();
        request(1'b1, n);
        for (int i = 0; i < 4 * int'(n); i++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL start_n%0d cyc=%0d got=%b exp=%b", n, cyc, obs_vec(), exp_vec());
            end
            if (i < 8) begin
                dpat[7-i] = div_clk;
                tpat[7-i] = tick;
            end
            step();
        end
        if (n == 4) begin
            n_cmp++;
            if (dpat !== 8'b1100_1100 || tpat !== 8'b0001_0001) begin
                n_bad++;
                $display("FAIL start4_pattern div_clk=%b tick=%b exp 11001100/00010001", dpat, tpat);
            end
        end
    endtask

    task automatic test_change();
        apply_reset();
        request(1'b1, 32'd4);
        step();
        request(1'b1, 32'd6);
        repeat (20) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL change_4_6 cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_invalid();
        apply_reset();
        request(1'b1, 32'd4);
        step();
        request(1'b1, 32'd1);
        repeat (10) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL invalid_run cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            step();
        end
        apply_reset();
        request(1'b1, 32'd0);
        repeat (4) begin
            n_cmp++;
            if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL invalid_stop cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_stop();
        apply_reset();
        request(1'b1, 32'd8);
        step();
        step();
        request(1'b0, 32'd0);
        repeat (12) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_n8 cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_random();
        apply_reset();
        repeat (1500) begin
            if (!cfg_valid && $urandom_range(0, 7) == 0) begin
                cfg_valid = 1'b1;
                cfg_run   = $urandom_range(0, 3) != 0;
                cfg_div   = $urandom_range(0, 9);
            end
            step();
            if (last_xfer) cfg_valid = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_wide();
        apply_reset();
        request(1'b1, 32'hFFFF_FFFF);
        repeat (20) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wide_div cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        request(1'b1, 32'd500000);
        repeat (10) step();
        n_cmp++;
        if (obs_vec() !== exp_vec() || div_clk !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre got=%b exp=%b", obs_vec(), exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== {1'b0, 1'b0, 1'b0, !AUTO, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_async got=%b exp=%b", obs_vec(), {1'b0, 1'b0, 1'b0, !AUTO, 1'b0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL midrst_after cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start(32'd4);
        test_start(32'd3);
        test_start(32'd2);
        test_change();
        test_invalid();
        test_stop();
        test_random();
        test_wide();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
